// File: rtl/rv32i_operand_stage.sv
// rv32i_operand_stage
//   Resolves rs1/rs2 against a priority-ordered set of forwarding sources,
//   builds ALU operands A and B, and registers them into the ID/EX boundary
//   behind a valid/ready handshake with load-use stall and flush.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   i_flush                  kill held and incoming operation
//   i_in_valid / o_in_ready  decode -> stage handshake
//   i_rs{1,2}_addr/_en/_data source index, read-enable (hazard only), RF data
//   i_imm, i_pc              immediate and PC
//   i_opa_sel, i_opb_sel     operand selects
//   i_fwd_valid/_busy/_rd/_data  forwarding sources, index 0 youngest
//   o_out_valid / i_out_ready    stage -> ALU handshake
//   o_op_a, o_op_b, o_store_data registered operands

// One source-operand lane: forwarding match plus load-use hazard.
module rv32i_operand_fwd_lane #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              i_addr,
  input  logic                    i_en,
  input  logic [XLEN-1:0]         i_rf_data,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD-1:0]      i_fwd_busy,
  input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
  output logic [XLEN-1:0]         o_value,
  output logic                    o_hazard
);
  logic            w_hit;
  logic            w_busy;
  logic [XLEN-1:0] w_data;

  // Walk oldest to youngest so the lowest matching index wins; a busy
  // young match therefore shadows any older ready one.
  always_comb begin
    w_hit  = 1'b0;
    w_busy = 1'b0;
    w_data = '0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_rd[i*5 +: 5] == i_addr)) begin
        w_hit  = 1'b1;
        w_busy = i_fwd_busy[i];
        w_data = i_fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_value  = i_rf_data;
    o_hazard = 1'b0;
    if (i_addr == 5'd0) begin
      o_value = '0;
    end else if (w_hit) begin
      o_value  = w_data;
      o_hazard = w_busy && i_en;
    end
  end
endmodule

module rv32i_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [4:0]              i_rs1_addr,
  input  logic [4:0]              i_rs2_addr,
  input  logic                    i_rs1_en,
  input  logic                    i_rs2_en,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [XLEN-1:0]         i_rs2_data,
  input  logic [XLEN-1:0]         i_imm,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [1:0]              i_opa_sel,
  input  logic [1:0]              i_opb_sel,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD-1:0]      i_fwd_busy,
  input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [XLEN-1:0]         o_op_a,
  output logic [XLEN-1:0]         o_op_b,
  output logic [XLEN-1:0]         o_store_data
);
  localparam int NUM_SRC = 2;  // lane 0 = rs1, lane 1 = rs2

  logic [NUM_SRC-1:0][4:0]      w_addr;
  logic [NUM_SRC-1:0]           w_en;
  logic [NUM_SRC-1:0][XLEN-1:0] w_rf;
  logic [NUM_SRC-1:0][XLEN-1:0] w_val;
  logic [NUM_SRC-1:0]           w_haz;

  assign w_addr = {i_rs2_addr, i_rs1_addr};
  assign w_en   = {i_rs2_en, i_rs1_en};
  assign w_rf   = {i_rs2_data, i_rs1_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    rv32i_operand_fwd_lane #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_lane (
      .i_addr      (w_addr[g]),
      .i_en        (w_en[g]),
      .i_rf_data   (w_rf[g]),
      .i_fwd_valid (i_fwd_valid),
      .i_fwd_busy  (i_fwd_busy),
      .i_fwd_rd    (i_fwd_rd),
      .i_fwd_data  (i_fwd_data),
      .o_value     (w_val[g]),
      .o_hazard    (w_haz[g])
    );
  end

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  always_comb begin
    w_op_a = '0;
    case (i_opa_sel)
      2'd0:    w_op_a = w_val[0];
      2'd1:    w_op_a = i_pc;
      default: w_op_a = '0;
    endcase
  end

  always_comb begin
    w_op_b = '0;
    case (i_opb_sel)
      2'd0:    w_op_b = w_val[1];
      2'd1:    w_op_b = i_imm;
      2'd2:    w_op_b = XLEN'(4);
      default: w_op_b = '0;
    endcase
  end

  logic r_out_valid;
  logic w_capture;

  assign o_in_ready  = !(|w_haz) && (!r_out_valid || i_out_ready);
  assign w_capture   = i_in_valid && o_in_ready && !i_flush;
  assign o_out_valid = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      o_op_a       <= '0;
      o_op_b       <= '0;
      o_store_data <= '0;
    end else begin
      if (i_flush)
        r_out_valid <= 1'b0;
      else if (w_capture)
        r_out_valid <= 1'b1;
      else if (r_out_valid && i_out_ready)
        r_out_valid <= 1'b0;
      if (w_capture) begin
        o_op_a       <= w_op_a;
        o_op_b       <= w_op_b;
        o_store_data <= w_val[1];
      end
    end
  end
endmodule

// File: tb/tb_rv32i_operand_stage.sv
// Directed bench for rv32i_operand_stage: reset, forwarding priority, x0,
// immediate/PC/constant selects, load-use stall, backpressure and flush.
module tb_rv32i_operand_stage;
  localparam int XLEN = 32;
  localparam int NF   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, in_valid, in_ready;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs1_en, rs2_en;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
  logic [1:0]      opa_sel, opb_sel;
  logic [NF-1:0]   fwd_valid, fwd_busy;
  logic [5*NF-1:0] fwd_rd;
  logic [XLEN*NF-1:0] fwd_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] op_a, op_b, store_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv32i_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .i_rs1_en     (rs1_en),
    .i_rs2_en     (rs2_en),
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .i_imm        (imm),
    .i_pc         (pc),
    .i_opa_sel    (opa_sel),
    .i_opb_sel    (opb_sel),
    .i_fwd_valid  (fwd_valid),
    .i_fwd_busy   (fwd_busy),
    .i_fwd_rd     (fwd_rd),
    .i_fwd_data   (fwd_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_op_a       (op_a),
    .o_op_b       (op_b),
    .o_store_data (store_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_en = 1'b1; rs2_en = 1'b1;
    rs1_data = 32'd5; rs2_data = 32'd7; imm = '0; pc = '0;
    opa_sel = 2'd0; opb_sel = 2'd0;
    fwd_valid = '0; fwd_busy = '0; fwd_rd = '0; fwd_data = '0;

    // reset holds everything clear even with in_valid high
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opa", op_a, 32'd0);
    chk("rst_opb", op_b, 32'd0);
    chk("rst_sd", store_data, 32'd0);
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_opa", op_a, 32'd5);
    chk("first_opb", op_b, 32'd7);
    chk("first_sd", store_data, 32'd7);

    // forward priority: youngest wins, then older after youngest drops
    rs1_addr = 5'd3; fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3};
    fwd_data = {32'hBB, 32'hAA};
    step();
    chk("fwd_young", op_a, 32'hAA);
    fwd_valid = 2'b10;
    step();
    chk("fwd_old", op_a, 32'hBB);

    // x0 never forwards; immediate select with forwarded store data
    rs1_addr = 5'd0; rs2_addr = 5'd2; fwd_valid = 2'b11;
    fwd_rd = {5'd2, 5'd0}; fwd_data = {32'h77, 32'h55};
    step();
    chk("x0_opa", op_a, 32'd0);
    chk("x0_opb_fwd", op_b, 32'h77);
    opb_sel = 2'd1; imm = 32'hFFFF_FFF0;
    step();
    chk("imm_opb", op_b, 32'hFFFF_FFF0);
    chk("imm_sd", store_data, 32'h77);

    // load-use stall on rs2
    opb_sel = 2'd0; rs1_addr = 5'd1; rs2_addr = 5'd4;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd4}; fwd_busy = 2'b01;
    fwd_data = {32'h0, 32'hDEAD};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_inrdy", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("stall_drained", {31'd0, out_valid}, 32'd0);
    fwd_busy = 2'b00; fwd_data = {32'h0, 32'h1234};
    #1;
    chk("unstall_inrdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);
    chk("unstall_opb", op_b, 32'h1234);
    chk("unstall_sd", store_data, 32'h1234);
    // busy match on an unused register is no hazard
    fwd_busy = 2'b01; rs2_en = 1'b0;
    #1;
    chk("nouse_inrdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("nouse_valid", {31'd0, out_valid}, 32'd1);
    // older ready match does not bypass a younger busy one
    rs2_en = 1'b1; fwd_valid = 2'b11; fwd_rd = {5'd4, 5'd4};
    #1;
    chk("shadow_inrdy", {31'd0, in_ready}, 32'd0);

    // backpressure
    fwd_valid = '0; fwd_busy = '0; rs2_addr = 5'd2;
    rs1_data = 32'h11; rs2_data = 32'h22;
    step();
    chk("bp_cap_opa", op_a, 32'h11);
    out_ready = 1'b0; rs1_data = 32'h33; rs2_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_opa", op_a, 32'h11);
      chk("bp_opb", op_b, 32'h22);
      chk("bp_inrdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_inrdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_opa", op_a, 32'h33);
    chk("b2b_opb", op_b, 32'h44);

    // flush while holding, with a new instruction offered
    out_ready = 1'b0; rs1_data = 32'h99;
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_nocap", op_a, 32'h33);
    flush = 1'b0;

    // PC and constant-4 selects
    opa_sel = 2'd1; opb_sel = 2'd2; pc = 32'h100;
    step();
    chk("pc_valid", {31'd0, out_valid}, 32'd1);
    chk("pc_opa", op_a, 32'h100);
    chk("c4_opb", op_b, 32'd4);
    // reserved selects read as zero
    out_ready = 1'b1; opa_sel = 2'd3; opb_sel = 2'd3;
    step();
    chk("rsv_opa", op_a, 32'd0);
    chk("rsv_opb", op_b, 32'd0);
    in_valid = 1'b0;
    step();
    chk("consume_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv32i_operand_stage.md
# rv32i_operand_stage

Parametrised successor to the single operand-B select. Selects both ALU operands from register data, immediate, PC, constants, or a set of forwarding sources, then registers them into the ID/EX boundary. The register uses a valid/ready handshake with load-use stall detection and flush. It sits between the register file/immediate generator and the ALU, and replaces the bare combinational rs2/imm select.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_FWD, 2, number of forwarding sources; index 0 is youngest (EX/MEM) and has highest priority

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the held and incoming operation
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_en, rs2_en  in  1 each  instruction actually reads rs1 / rs2 (hazard check only)
- rs1_data, rs2_data  in  XLEN each  register-file read data
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction PC
- opa_sel  in  2  operand A select: 0 rs1, 1 pc, 2 zero, 3 reserved (treated as zero)
- opb_sel  in  2  operand B select: 0 rs2, 1 imm, 2 constant 4, 3 reserved (treated as zero)
- fwd_valid  in  NUM_FWD  source i holds a pending write
- fwd_busy  in  NUM_FWD  source i's data is not yet available (load in flight)
- fwd_rd  in  5*NUM_FWD  destination index of source i, packed
- fwd_data  in  XLEN*NUM_FWD  result of source i, packed
- out_valid  out  1  registered operands valid toward the ALU
- out_ready  in  1  ALU stage consumes the operands
- op_a, op_b  out  XLEN each  registered operands
- store_data  out  XLEN  registered forwarded rs2 value for stores

## Operation
Forwarding resolution (combinational), for each of rs1 and rs2:
- If the address is 0, the value is 0, no forward, no hazard.
- Otherwise, take the lowest index i with fwd_valid[i] and fwd_rd[i] equal to the address.
  - If that source has fwd_busy[i]=0, the value is fwd_data[i].
  - If no source matches, the value is rs*_data.
- Hazard: the matched lowest-index source has fwd_busy=1 and the corresponding rs*_en=1.
  - A busy match on an unused register is not a hazard.
  - An older non-busy match does not bypass a younger busy one.

Operand build:
- op_a is taken from the resolved rs1, pc, or 0 per opa_sel.
- op_b is taken from the resolved rs2, imm, 32'd4 (zero-extended to XLEN), or 0 per opb_sel.
- store_data is always the resolved rs2.

Handshake:
- in_ready = !hazard && (!out_valid || out_ready).
- Capture occurs when in_valid && in_ready && !flush. On capture, op_a, op_b and store_data are loaded and out_valid is set to 1.
- On out_valid && out_ready with no capture, out_valid is cleared to 0.
- When neither capture nor consume occurs, all outputs hold. Data is stable while out_valid=1 and out_ready=0.
- flush=1 forces out_valid to 0 next edge, regardless of in_valid and out_ready. Data registers may hold stale values.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, op_a=0, op_b=0, store_data=0. in_ready then follows hazard and out_ready combinationally.
- Latency: 1 cycle from capture edge to out_valid=1.
- Throughput: 1 per cycle while out_ready=1 and there is no hazard.
- in_ready has a combinational path from out_ready, fwd_* and rs*_en. There is no combinational path from in_valid to in_ready.
- A hazard holds in_ready=0 every cycle until the matching fwd_busy drops. Capture occurs in the same cycle the busy flag falls, using that cycle's fwd_data.
- Simultaneous consume and capture: out_valid stays 1 and the new data replaces the old.
- Reset released mid-stream: the first capture happens no earlier than the first rising edge after deassertion.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0 and op_a=op_b=store_data=0. Deassert with no forwards, rs1_data=5, rs2_data=7, opa_sel=0, opb_sel=0 -> one cycle later op_a=5, op_b=7, store_data=7.
- Forward priority: rs1_addr=3, fwd_rd={3,3}, fwd_data[0]=0xAA, fwd_data[1]=0xBB, both valid and not busy -> op_a=0xAA. Drop fwd_valid[0] -> op_a=0xBB.
- x0 and immediate: rs1_addr=0 with fwd_rd[0]=0 valid, fwd_data=0x55, opa_sel=0 -> op_a=0. Set opb_sel=1, imm=0xFFFFFFF0 -> op_b=0xFFFFFFF0 while store_data still shows the forwarded rs2.
- Load-use stall: fwd_rd[0]=4, busy=1, rs2_addr=4, rs2_en=1 -> in_ready=0 for 3 cycles. Drop busy with fwd_data=0x1234 -> capture that cycle, next cycle op_b=0x1234. Repeat with rs2_en=0 -> no stall.
- Backpressure: out_ready=0 for 4 cycles after a capture -> out_valid=1, operands stable, in_ready=0. Raise out_ready with in_valid=1 -> back-to-back transfer and new operands next cycle.
- Flush: assert flush while out_valid=1, out_ready=0, in_valid=1 -> out_valid=0 next cycle and nothing captured. Also apply PC select with opb_sel=2, pc=0x100 -> op_a=0x100, op_b=4.
